// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4
//   Registered 1-to-4 stream demultiplexer. Each accepted input word is
//   routed by `sel` into a one-entry register on one of four output
//   channels. Each channel also keeps a saturating count of the words it
//   has accepted.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. The producer holds its data stable while valid=1 and ready=0.
//   The input side uses in_valid/in_ready, and channel k uses
//   y_valid[k]/y_ready[k].
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   d, sel             input word and its destination channel (0..3)
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   y0..y3             per-channel registered data
//   y_valid/y_ready    per-channel output handshake, one bit per channel
//   cnt0..cnt3         per-channel accepted-word counters (saturating)
//
// Channel state is just its y_valid bit (EMPTY=0 / FULL=1), so y_valid is
// also the observable state of every channel.
module stream_demux_1_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [WIDTH-1:0] y_q   [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       load;
  logic [3:0]       drain;

  // Only the addressed channel gates the input, so a stalled channel never
  // blocks traffic headed for the others. A full channel that is draining
  // this cycle can take a new word on the same edge.
  assign in_ready = ~rst & (~y_valid[sel] | y_ready[sel]);

  always_comb begin
    load  = '0;
    drain = '0;
    for (int k = 0; k < 4; k++) begin
      load[k]  = in_valid & in_ready & (sel == 2'(k));
      drain[k] = y_valid[k] & y_ready[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= '0;
      for (int k = 0; k < 4; k++) begin
        y_q[k]   <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          // A load takes priority over a drain on the same edge. The
          // channel stays full and holds the new word.
          y_q[k]     <= d;
          y_valid[k] <= 1'b1;
          if (cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end else if (drain[k]) begin
          // The data is kept after a drain; only the flag clears.
          y_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign y0   = y_q[0];
  assign y1   = y_q[1];
  assign y2   = y_q[2];
  assign y3   = y_q[3];
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed table, hand-written corner sequences
// and randomized traffic, all checked against a per-channel reference model.
module tb_stream_demux_1_4;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       y_valid;
  logic [3:0]       y_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  always #5 clk = ~clk;

  stream_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .y_valid(y_valid), .y_ready(y_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  // ---------------- reference model ----------------
  // Each channel is modelled as a full flag, a held word and an integer
  // count of accepted words, capped at CNT_MAX.
  bit               m_full [4];
  logic [WIDTH-1:0] m_data [4];
  int               m_cnt  [4];

  int checks   = 0;
  int failures = 0;

  function automatic logic [WIDTH-1:0] dut_y(input int k);
    case (k)
      0: return y0;
      1: return y1;
      2: return y2;
      default: return y3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dut_cnt(input int k);
    case (k)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  function automatic bit model_ready();
    if (rst) return 1'b0;
    return !m_full[sel] || y_ready[sel];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks every registered output against the model, and in_ready against
  // the model when sel is known.
  task automatic check_all(input string tag);
    logic [3:0] exp_v;
    for (int k = 0; k < 4; k++) exp_v[k] = m_full[k];
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(exp_v));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.y%0d", tag, k), 32'(dut_y(k)), 32'(m_data[k]));
      chk($sformatf("%s.cnt%0d", tag, k), 32'(dut_cnt(k)), 32'(m_cnt[k]));
    end
    if (!$isunknown(sel)) chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] dd,
                       input logic [3:0] yr);
    in_valid = v;
    sel      = s;
    d        = dd;
    y_ready  = yr;
  endtask

  // Advances one clock and applies the same edge to the model. Inputs are
  // only changed on the falling edge, so they are stable at the rising edge.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
        m_cnt[k]  = 0;
      end
    end else begin
      acc = in_valid && (!m_full[sel] || y_ready[sel]);
      for (int k = 0; k < 4; k++) begin
        if (acc && sel == 2'(k)) begin
          m_full[k] = 1'b1;
          m_data[k] = d;
          m_cnt[k]  = (m_cnt[k] < CNT_MAX) ? m_cnt[k] + 1 : CNT_MAX;
        end else if (m_full[k] && y_ready[k]) begin
          m_full[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic             v;
    logic [1:0]       s;
    logic [WIDTH-1:0] dd;
    logic [3:0]       yr;
    logic             exp_rdy;   // in_ready before the edge
    logic [3:0]       exp_yv;    // y_valid after the edge
    logic [WIDTH-1:0] exp_ysel;  // y[s] after the edge
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Routing a,b,c,d = 3,A,C,D to channels 0..3 with no consumers ready.
    vecs[0] = '{1'b1, 2'd0, 4'h3, 4'b0000, 1'b1, 4'b0001, 4'h3};
    vecs[1] = '{1'b1, 2'd1, 4'hA, 4'b0000, 1'b1, 4'b0011, 4'hA};
    vecs[2] = '{1'b1, 2'd2, 4'hC, 4'b0000, 1'b1, 4'b0111, 4'hC};
    vecs[3] = '{1'b1, 2'd3, 4'hD, 4'b0000, 1'b1, 4'b1111, 4'hD};
    // A 5th write to the full channel 2 is refused.
    vecs[4] = '{1'b1, 2'd2, 4'hE, 4'b0000, 1'b0, 4'b1111, 4'hC};
    // Stall isolation: channel 1 is full and stalled, so sel=1 is refused.
    vecs[5] = '{1'b1, 2'd1, 4'h7, 4'b0000, 1'b0, 4'b1111, 4'hA};
    // Drain channel 3 on its own, then send to it while channel 1 stays stalled.
    vecs[6] = '{1'b0, 2'd3, 4'h0, 4'b1000, 1'b1, 4'b0111, 4'hD};
    vecs[7] = '{1'b1, 2'd3, 4'h5, 4'b0000, 1'b1, 4'b1111, 4'h5};
    // Simultaneous drain and load on channel 0 (holding 3).
    vecs[8] = '{1'b1, 2'd0, 4'h9, 4'b0001, 1'b1, 4'b1111, 4'h9};
    // Channel 1 is still stalled and still refuses.
    vecs[9] = '{1'b1, 2'd1, 4'h6, 4'b0000, 1'b0, 4'b1111, 4'hA};

    rst = 1'b1;
    drive(1'b1, 2'd0, 4'hF, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0; m_data[k] = '0; m_cnt[k] = 0;
    end
    @(negedge clk);
    tick();
    tick();

    // Reset state, checked against constants.
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.y_valid", 32'(y_valid), 32'd0);
    chk("rst.y0", 32'(y0), 32'd0);
    chk("rst.cnt3", 32'(cnt3), 32'd0);
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].dd, vecs[i].yr);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d.y_valid", i), 32'(y_valid), 32'(vecs[i].exp_yv));
      chk($sformatf("vec%0d.ysel", i), 32'(dut_y(int'(vecs[i].s))), 32'(vecs[i].exp_ysel));
      check_all($sformatf("vec%0d", i));
    end
    chk("route.cnt0", 32'(cnt0), 32'd2);
    chk("route.cnt1", 32'(cnt1), 32'd1);

    // ---- 10 back-to-back words into channel 0 while it drains ----
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd0, WIDTH'(i + 1), 4'b0001);
      #1;
      chk($sformatf("b2b%0d.in_ready", i), 32'(in_ready), 32'd1);
      tick();
      chk($sformatf("b2b%0d.y0", i), 32'(y0), 32'(i + 1));
      chk($sformatf("b2b%0d.yv0", i), 32'(y_valid[0]), 32'd1);
    end
    chk("b2b.cnt0", 32'(cnt0), 32'd12);

    // ---- drain without load, then idle with X on d/sel ----
    drive(1'b0, 2'd0, 4'h0, 4'b0100);
    tick();
    chk("drain.yv2", 32'(y_valid[2]), 32'd0);
    chk("drain.y2", 32'(y2), 32'hC);
    check_all("drain");
    drive(1'b0, 'x, 'x, 4'b0000);
    tick();
    check_all("idle_x");
    chk("idle_x.y_valid", 32'(y_valid), 32'b1011);

    // ---- counter saturation on channel 3 ----
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, WIDTH'($urandom_range(0, 15)), 4'b1000);
      tick();
    end
    chk("sat.cnt3", 32'(cnt3), 32'd255);
    chk("sat.cnt0", 32'(cnt0), 32'd12);
    chk("sat.cnt1", 32'(cnt1), 32'd1);
    chk("sat.cnt2", 32'(cnt2), 32'd1);
    check_all("sat");

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            WIDTH'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      chk($sformatf("rnd%0d.in_ready", i), 32'(in_ready), 32'(model_ready()));
      tick();
      check_all($sformatf("rnd%0d", i));
    end
    rst = 1'b0;

    // ---- reset mid-operation ----
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), WIDTH'(k + 8), 4'b0000);
      tick();
    end
    chk("fill.y_valid", 32'(y_valid), 32'hF);
    rst = 1'b1;
    drive(1'b1, 2'd0, 4'h1, 4'b0000);
    #1;
    chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst.y_valid", 32'(y_valid), 32'd0);
    chk("post_rst.y1", 32'(y1), 32'd0);
    chk("post_rst.cnt2", 32'(cnt2), 32'd0);
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Registered 1-to-4 stream demultiplexer: the inverse of the team's 4:1 mux.
- Routes each accepted input word to one of four output channels, chosen by `sel`.
- Each output channel has a one-entry pipeline register with a valid/ready handshake.
- Per-channel transfer counters are kept for debug and verification.

Parameters:
- WIDTH, 4, data width of the input and of every output channel.
- CNT_W, 8, width of each per-channel saturating transfer counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- d  input  WIDTH  input data word.
- sel  input  2  destination channel for `d`: 0→y0, 1→y1, 2→y2, 3→y3.
- in_valid  input  1  `d`/`sel` are valid this cycle.
- in_ready  output  1  the block accepts `d` this cycle.
- y0, y1, y2, y3  output  WIDTH each  per-channel registered data.
- y_valid  output  4  bit k set: yk holds a word not yet consumed.
- y_ready  input  4  bit k set: the consumer of channel k accepts this cycle.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  accepted-word count per channel, saturating.

Behaviour:
- Reset: while `rst`=1 at a rising edge, the following all become 0 on that edge:
  - `y_valid` = 4'b0000
  - y0..y3 = 0
  - cnt0..cnt3 = 0
  - In-flight words are discarded, with no partial state.
- Reset mid-operation: a word held in any channel is dropped; `y_valid` is 0 from the next cycle.
- `in_ready` is combinational:
  - in_ready = ~rst & ( ~y_valid[sel] | y_ready[sel] ).
  - It depends only on the selected channel; a stalled channel never blocks traffic to the others.
- Input transfer: occurs on a rising edge when in_valid & in_ready. On the edge:
  - y[sel] ← d and y_valid[sel] ← 1.
  - cnt[sel] increments by 1, saturating at 2^CNT_W−1 (no wrap).
- Output transfer on channel k: occurs when y_valid[k] & y_ready[k].
  - If channel k is not loaded on the same edge, y_valid[k] ← 0.
  - Data yk is held (not cleared) after the drain.
- Simultaneous drain and load of the same channel k: the new word is loaded and y_valid[k] stays 1. Full throughput is one word per cycle per channel.
- Latency: a word accepted at edge N is visible on yk with y_valid[k]=1 immediately after edge N (1 cycle, input to output).
- Channels not addressed by `sel` are unaffected by the input, except for their own drains.
- Output stability: while y_valid[k]=1 and y_ready[k]=0, yk and y_valid[k] must not change.
- Idle input: when in_valid=0, `d` and `sel` are ignored, including X values. No state change results except drains.
- y_ready[k] while y_valid[k]=0 has no effect.
- Counters count input acceptances only, not drains.
- No other state machine: each channel is an independent EMPTY/FULL flag, with transitions as above.

Test Plan:
- Reset and routing: assert rst, then write d=a,b,c,d to sel=0,1,2,3 with all y_ready=0. Required:
  - in_ready=1 on each write; y0=a, y1=b, y2=c, y3=d.
  - y_valid=4'b1111; cnt0..cnt3=1.
  - A 5th write with sel=2 sees in_ready=0.
- Stall isolation: channel 1 is full with y_ready[1]=0. Present sel=1, d=7 → in_ready=0, y1 unchanged. Switch to sel=3, d=5 → accepted, y3=5.
- Simultaneous drain and load: channel 0 holds 3; y_ready[0]=1, in_valid=1, sel=0, d=9. Required:
  - in_ready=1.
  - Next cycle y0=9, y_valid[0]=1, cnt0 incremented.
  - Hold y_ready[0]=1 for 10 back-to-back words: all 10 are accepted, one per cycle.
- Drain without load: y_ready[2]=1 and in_valid=0 → y_valid[2] falls to 0 next cycle; y2 keeps its last value. With in_valid=0 and d/sel=X: no state change.
- Counter saturation: with CNT_W=8, send 300 words to channel 3 with y_ready[3]=1. Required: cnt3=255, cnt0..cnt2 unchanged.
- Reset mid-operation: fill all channels, assert rst for one cycle. Required:
  - y_valid=0, all cnt=0, y0..y3=0.
  - in_ready=0 during the reset cycle, 1 after it.
